// File: rtl/bin_xs3_conv_pkg.sv
// Shared types and constants for the binary to BCD / excess-3 converter.
// Imported by the converter top and its digit-adjust cell.
package bin_xs3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic       MODE_BCD = 1'b0;
    localparam logic       MODE_XS3 = 1'b1;
    localparam logic [3:0] XS3_BIAS = 4'd3;

    // Bit-counter width for a given input width; never narrower than one bit.
    function automatic int cnt_w(input int bin_w);
        return (bin_w > 1) ? $clog2(bin_w) : 1;
    endfunction

endpackage

// File: rtl/bin_xs3_conv_dd_digit_adj.sv
// Combinational 4-bit digit adjust: +3 when cond_en and digit >= 5 (double-dabble step),
// or +3 unconditionally when force_en (excess-3 output bias). No carry out.
module dd_digit_adj
    import bin_xs3_pkg::*;
(
    input  logic       cond_en,
    input  logic       force_en,
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (force_en || (cond_en && (digit_in >= 4'd5)))
            digit_out = digit_in + XS3_BIAS;
    end

endmodule

// File: rtl/bin_xs3_conv.sv
// Sequential double-dabble converter, one input bit per clock, with valid/ready on both sides.
// Produces packed BCD or excess-3 digits; out_ovf flags values that do not fit in DIGITS.
module bin_xs3_conv
    import bin_xs3_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_digits,
    output logic                  out_ovf
);

    localparam int CNT_W = cnt_w(BIN_W);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   digits_biased;
    logic [SR_W-1:0]    sr_shift;
    logic               mode_r;
    logic               ovf_r;
    logic               shift_out;
    logic [CNT_W-1:0]   cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_shift_adj
        dd_digit_adj u_adj (
            .cond_en   (1'b1),
            .force_en  (1'b0),
            .digit_in  (bcd[4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    assign sr_shift  = {bcd_adj, bin_sr} << 1;
    assign bcd_shift = sr_shift[SR_W-1:BIN_W];
    assign shift_out = bcd_adj[BCD_W-1];

    // Bias is applied to the value the final shift produces, so DONE entry needs no extra cycle.
    for (genvar g = 0; g < DIGITS; g++) begin : g_out_bias
        dd_digit_adj u_bias (
            .cond_en   (1'b0),
            .force_en  (mode_r == MODE_XS3),
            .digit_in  (bcd_shift[4*g +: 4]),
            .digit_out (digits_biased[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = SHIFT;
            SHIFT:   if (cnt == '0)    state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr     <= '0;
            bcd        <= '0;
            mode_r     <= MODE_BCD;
            ovf_r      <= 1'b0;
            cnt        <= '0;
            out_digits <= '0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= in_bin;
                        mode_r <= in_mode;
                        bcd    <= '0;
                        ovf_r  <= 1'b0;
                        cnt    <= CNT_W'(BIN_W - 1);
                    end
                end
                SHIFT: begin
                    {bcd, bin_sr} <= sr_shift;
                    ovf_r         <= ovf_r | shift_out;
                    if (cnt == '0) begin
                        out_digits <= digits_biased;
                        out_ovf    <= ovf_r | shift_out;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_xs3_conv.sv
// Self-checking bench for bin_xs3_conv across four width/digit configurations.
// Expected digits come from a decimal arithmetic model (value mod 10^DIGITS, optional +3).
`timescale 1ns/1ps
module tb_bin_xs3_conv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid [4];
    logic        in_mode  [4];
    logic        out_ready[4];
    logic        in_ready [4];
    logic        out_valid[4];
    logic        out_ovf  [4];
    logic [15:0] in_bin   [4];
    logic [15:0] od       [4];
    logic [11:0] od0;
    logic [7:0]  od1;
    logic [3:0]  od2;
    logic [11:0] od3;

    assign od[0] = {4'h0, od0};
    assign od[1] = {8'h0, od1};
    assign od[2] = {12'h0, od2};
    assign od[3] = {4'h0, od3};

    bin_xs3_conv #(.BIN_W(8), .DIGITS(3)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bin(in_bin[0][7:0]), .in_mode(in_mode[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_digits(od0), .out_ovf(out_ovf[0]));
    bin_xs3_conv #(.BIN_W(8), .DIGITS(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bin(in_bin[1][7:0]), .in_mode(in_mode[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_digits(od1), .out_ovf(out_ovf[1]));
    bin_xs3_conv #(.BIN_W(1), .DIGITS(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bin(in_bin[2][0:0]), .in_mode(in_mode[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_digits(od2), .out_ovf(out_ovf[2]));
    bin_xs3_conv #(.BIN_W(13), .DIGITS(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_bin(in_bin[3][12:0]), .in_mode(in_mode[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .out_digits(od3), .out_ovf(out_ovf[3]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cur     = -1;

    int          acc_cyc  [$];
    logic [15:0] acc_bin  [$];
    logic        acc_mode [$];
    logic [15:0] out_dig_q[$];
    logic        out_ovf_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake recorder for the DUT currently under test; sampled mid-cycle.
    always @(negedge clk) begin
        if (cur >= 0) begin
            if (in_valid[cur] && in_ready[cur]) begin
                acc_cyc.push_back(cyc);
                acc_bin.push_back(in_bin[cur]);
                acc_mode.push_back(in_mode[cur]);
            end
            if (out_valid[cur] && out_ready[cur]) begin
                out_dig_q.push_back(od[cur]);
                out_ovf_q.push_back(out_ovf[cur]);
            end
        end
    end

    function automatic int bw_of(input int k);
        case (k)
            0: return 8;
            1: return 8;
            2: return 1;
            default: return 13;
        endcase
    endfunction

    function automatic int dg_of(input int k);
        case (k)
            0: return 3;
            1: return 2;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [15:0] mask_of(input int k);
        return 16'((32'd1 << (4 * dg_of(k))) - 32'd1);
    endfunction

    function automatic void ref_conv(input int dg, input int unsigned v, input logic mode,
                                     output logic [15:0] dig, output logic ovf);
        int unsigned p = 1;
        int unsigned r;
        for (int i = 0; i < dg; i++) p = p * 10;
        ovf = (v >= p);
        r   = v % p;
        dig = '0;
        for (int i = 0; i < dg; i++) begin
            dig[4*i +: 4] = 4'((r % 10) + (mode ? 3 : 0));
            r = r / 10;
        end
    endfunction

    function automatic void clear_q();
        acc_cyc.delete(); acc_bin.delete(); acc_mode.delete();
        out_dig_q.delete(); out_ovf_q.delete();
    endfunction

    // Drives one conversion on DUT k; called #1 after a rising edge.
    task automatic do_conv(input int k, input int unsigned v, input logic mode, input bit release_out,
                           output logic [15:0] dig, output logic ovf, output int lat, output bit tmo);
        int w = 0;
        cur = k;
        tmo = 1'b0;
        in_bin[k]   = 16'(v);
        in_mode[k]  = mode;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && w < 50) begin @(posedge clk); #1; w++; end
        if (!in_ready[k]) tmo = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!out_valid[k]) tmo = 1'b1;
        dig = od[k] & mask_of(k);
        ovf = out_ovf[k];
        if (release_out) begin
            out_ready[k] = 1'b1;
            @(posedge clk); #1;
            out_ready[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({in_ready[k], out_valid[k], out_ovf[k], od[k]} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
                n_fail++;
                $display("FAIL reset_in_reset dut%0d got rdy=%b vld=%b ovf=%b dig=%h want 1 0 0 0",
                         k, in_ready[k], out_valid[k], out_ovf[k], od[k]);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({in_ready[k], out_valid[k]} !== 2'b10) begin
                n_fail++;
                $display("FAIL reset_release dut%0d got rdy=%b vld=%b want 1 0", k, in_ready[k], out_valid[k]);
            end
        end
    endtask

    task automatic test_directed();
        int          ks[6] = '{0, 0, 0, 0, 1, 1};
        int unsigned vs[6] = '{255, 255, 99, 0, 255, 99};
        logic        ms[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] ed[6] = '{16'h255, 16'h588, 16'h3CC, 16'h333, 16'h055, 16'h099};
        logic        eo[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] dig;
        logic        ovf;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 6; i++) begin
            do_conv(ks[i], vs[i], ms[i], 1'b1, dig, ovf, lat, tmo);
            n_tests++;
            if (tmo || dig !== ed[i] || ovf !== eo[i]) begin
                n_fail++;
                $display("FAIL directed_%0d dut%0d v=%0d mode=%b got dig=%h ovf=%b tmo=%b want dig=%h ovf=%b",
                         i, ks[i], vs[i], ms[i], dig, ovf, tmo, ed[i], eo[i]);
            end
            n_tests++;
            if (lat !== bw_of(ks[i])) begin
                n_fail++;
                $display("FAIL latency_%0d got out_valid in cycle %0d want %0d", i, lat + 1, bw_of(ks[i]) + 1);
            end
        end
    endtask

    task automatic test_hold();
        logic [15:0] dig, ed, ed2;
        logic        ovf, eo, eo2;
        int          lat, w, c0;
        bit          tmo;
        int unsigned v2;
        clear_q();
        do_conv(0, 173, 1'b1, 1'b0, dig, ovf, lat, tmo);
        ref_conv(3, 173, 1'b1, ed, eo);
        clear_q();
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'($urandom);
            in_bin[0]   = 16'($urandom);
            @(posedge clk); #1;
            n_tests++;
            if (tmo || {out_valid[0], in_ready[0], out_ovf[0], od[0]} !== {1'b1, 1'b0, eo, ed}) begin
                n_fail++;
                $display("FAIL hold_stable cyc%0d got vld=%b rdy=%b ovf=%b dig=%h want 1 0 %b %h",
                         i, out_valid[0], in_ready[0], out_ovf[0], od[0], eo, ed);
            end
        end
        n_tests++;
        if (acc_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL hold_no_accept got %0d accepts want 0", acc_cyc.size());
        end
        v2 = $urandom % 256;
        in_bin[0]    = 16'(v2);
        in_mode[0]   = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        c0 = cyc;
        w  = 0;
        while (acc_cyc.size() == 0 && w < 20) begin @(posedge clk); #1; w++; end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        n_tests++;
        if (acc_cyc.size() == 0 || acc_cyc[0] != c0 + 1) begin
            n_fail++;
            $display("FAIL turnaround got accept at cycle %0d want %0d",
                     (acc_cyc.size() == 0) ? -1 : acc_cyc[0] - c0 + 1, 2);
        end
        lat = 0;
        while (!out_valid[0] && lat < 50) begin @(posedge clk); #1; lat++; end
        ref_conv(3, v2, 1'b0, ed2, eo2);
        n_tests++;
        if (!out_valid[0] || od[0] !== ed2 || out_ovf[0] !== eo2) begin
            n_fail++;
            $display("FAIL hold_next_conv v=%0d got vld=%b dig=%h ovf=%b want 1 %h %b",
                     v2, out_valid[0], od[0], out_ovf[0], ed2, eo2);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] dig;
        logic        ovf;
        int          lat, w;
        bit          tmo, seen;
        cur = 0;
        in_bin[0]   = 16'd200;
        in_mode[0]  = 1'b1;
        in_valid[0] = 1'b1;
        w = 0;
        while (!in_ready[0] && w < 50) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({in_ready[k], out_valid[k], out_ovf[k], od[k]} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
                n_fail++;
                $display("FAIL reset_async dut%0d got rdy=%b vld=%b ovf=%b dig=%h want 1 0 0 0",
                         k, in_ready[k], out_valid[k], out_ovf[k], od[k]);
            end
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid[0] || !in_ready[0]) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_discard got stale activity=1 want 0");
        end
        do_conv(0, 37, 1'b0, 1'b1, dig, ovf, lat, tmo);
        n_tests++;
        if (tmo || dig !== 16'h037 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_then_37 got dig=%h ovf=%b tmo=%b want 037 0", dig, ovf, tmo);
        end
    endtask

    task automatic test_random();
        int          ks[3] = '{2, 0, 3};
        logic [15:0] dig, ed;
        logic        ovf, eo, m;
        int          lat;
        bit          tmo;
        int unsigned v;
        foreach (ks[j]) begin
            for (int i = 0; i < 12; i++) begin
                v = $urandom % (32'd1 << bw_of(ks[j]));
                m = 1'($urandom);
                do_conv(ks[j], v, m, 1'b1, dig, ovf, lat, tmo);
                ref_conv(dg_of(ks[j]), v, m, ed, eo);
                n_tests++;
                if (tmo || dig !== ed || ovf !== eo) begin
                    n_fail++;
                    $display("FAIL random dut%0d v=%0d mode=%b got dig=%h ovf=%b tmo=%b want dig=%h ovf=%b",
                             ks[j], v, m, dig, ovf, tmo, ed, eo);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int          ks[3] = '{2, 0, 3};
        logic [15:0] ed;
        logic        eo;
        int          k, last, w;
        foreach (ks[j]) begin
            k = ks[j];
            clear_q();
            cur = k;
            out_ready[k] = 1'b1;
            in_bin[k]    = 16'($urandom % (32'd1 << bw_of(k)));
            in_mode[k]   = 1'($urandom);
            in_valid[k]  = 1'b1;
            last = 0;
            w    = 0;
            while (acc_cyc.size() < 6 && w < 400) begin
                @(posedge clk); #1; w++;
                if (acc_cyc.size() != last) begin
                    last = acc_cyc.size();
                    in_bin[k]  = 16'($urandom % (32'd1 << bw_of(k)));
                    in_mode[k] = 1'($urandom);
                end
            end
            in_valid[k] = 1'b0;
            w = 0;
            while (out_dig_q.size() < acc_cyc.size() && w < 100) begin @(posedge clk); #1; w++; end
            out_ready[k] = 1'b0;
            n_tests++;
            if (acc_cyc.size() != 6 || out_dig_q.size() != 6) begin
                n_fail++;
                $display("FAIL b2b_count dut%0d got acc=%0d out=%0d want 6 6", k, acc_cyc.size(), out_dig_q.size());
            end else begin
                for (int i = 0; i < 6; i++) begin
                    ref_conv(dg_of(k), int'(acc_bin[i]), acc_mode[i], ed, eo);
                    n_tests++;
                    if ((out_dig_q[i] & mask_of(k)) !== ed || out_ovf_q[i] !== eo) begin
                        n_fail++;
                        $display("FAIL b2b_data dut%0d #%0d v=%0d got dig=%h ovf=%b want dig=%h ovf=%b",
                                 k, i, acc_bin[i], out_dig_q[i] & mask_of(k), out_ovf_q[i], ed, eo);
                    end
                    if (i > 0) begin
                        n_tests++;
                        if (acc_cyc[i] - acc_cyc[i-1] != bw_of(k) + 2) begin
                            n_fail++;
                            $display("FAIL b2b_period dut%0d #%0d got %0d cycles want %0d",
                                     k, i, acc_cyc[i] - acc_cyc[i-1], bw_of(k) + 2);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            in_mode[k]   = 1'b0;
            out_ready[k] = 1'b0;
            in_bin[k]    = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_xs3_conv.md
# bin_xs3_conv

Sequential, parametrised binary-to-decimal converter producing packed BCD or excess-3 digits. It uses the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. Valid/ready handshakes sit on both sides. It is the multi-digit, mode-selectable successor to the team's single-digit combinational BCD-to-excess-3 encoder, and it sits between binary datapath results and display or decimal-I/O logic.

## Interface
- BIN_W, 8: binary input width, at least 1.
- DIGITS, 3: number of output decimal digits, at least 1. Undersizing is legal and is reported via out_ovf.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bin and in_mode are valid.
- in_ready  out  1  converter can accept; high only in IDLE.
- in_bin  in  BIN_W  unsigned binary value.
- in_mode  in  1  0 = BCD output, 1 = excess-3 output.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_digits  out  4*DIGITS  packed digits; digit 0 is at [3:0].
- out_ovf  out  1  value ≥ 10^DIGITS; out_digits holds value mod 10^DIGITS.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_bin into the shift register, latch in_mode, clear the BCD register and ovf, set cnt = BIN_W-1, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every BCD digit ≥ 5 gets +3 (4-bit result).
  - Then {bcd, bin} shifts left 1.
  - The bit shifted out of the top digit's MSB ORs into ovf (sticky).
  - At cnt == 0: go to DONE; otherwise cnt decrements.
- Entering DONE: out_digits is loaded from the BCD register. Each digit gets +3 if mode = 1; otherwise it passes unchanged.
- DONE:
  - out_valid = 1. out_digits and out_ovf are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE. out_valid drops on the next edge.
- Arithmetic:
  - All digit adds are 4-bit, with no carry between digits.
  - In BCD mode, digits are 0..9. In excess-3 mode, digits are 3..12 (0x3..0xC).
  - Truncated (overflowed) results equal value mod 10^DIGITS, with excess-3 applied on top.
- in_valid outside IDLE is ignored, and in_bin is not sampled.
- There is no same-cycle turnaround: the next accept happens no earlier than the cycle after the DONE→IDLE transition.
- Reset (asserted at any time, including mid-SHIFT or in DONE):
  - Aborts immediately to IDLE.
  - out_valid = 0, out_digits = 0, out_ovf = 0, in_ready = 1 (IDLE).
  - Internal registers and cnt go to 0.
  - A partially converted value is discarded and never presented.

## Timing
- Accept in cycle 0, with the handshake on that rising edge.
- SHIFT occupies cycles 1..BIN_W.
- out_valid is high from cycle BIN_W+1. Latency is BIN_W+1 cycles.
- Minimum period between accepts is BIN_W+2 cycles when out_ready is held high.
- All outputs are registered. in_ready is decoded from the state register only and has no combinational path from any input.
- out_digits and out_ovf may change only on entry to DONE or on reset.

## Structure
- Package bin_xs3_pkg holds:
  - state enum (IDLE, SHIFT, DONE).
  - mode constants MODE_BCD = 0 and MODE_XS3 = 1.
  - constant XS3_BIAS = 4'd3.
  - localparam CNT_W = $clog2(BIN_W) (minimum 1).
- Sub-module dd_digit_adj is a combinational 4-bit digit adjust: it adds 3 when the input is ≥ 5 in SHIFT, or adds the bias unconditionally for the excess-3 output stage.
- The top level instantiates it DIGITS times in a generate loop for the shift stage, plus a separate output-bias loop.

## Test plan
- BIN_W=8, DIGITS=3, mode 0, in_bin 255 -> out_digits 0x255, out_ovf 0, out_valid exactly 9 cycles after the accept cycle.
- Same configuration, mode 1: 255 -> 0x588; 99 -> 0x3CC; 0 -> 0x333, all with ovf 0.
- BIN_W=8, DIGITS=2, mode 0: 255 -> 0x55 with ovf 1; 99 -> 0x99 with ovf 0.
- Hold out_ready low 10 cycles in DONE while toggling in_valid and in_bin -> outputs stable, in_ready 0, no extra accept. Raise out_ready -> next accept occurs 2 cycles later at the earliest.
- Assert rst_n low during cycle 4 of SHIFT -> all outputs return to reset values asynchronously. After release, convert 37 in mode 0 -> 0x037 with no stale bits.
- Random sweep over BIN_W ∈ {1, 8, 13} and both modes against a reference model of value mod 10^DIGITS, checking ovf and back-to-back throughput of BIN_W+2 cycles.
